skolem_sweep_checker: RTL
=========================

SKOLEM_SWEEP_CHECKER -- requirements
Module: skolem_sweep_checker

Interface
REQ-001 clk  input  1  single rising-edge clock; all state changes on its rising edge.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 start  input  1  one-cycle pulse; begins a full sweep when in IDLE; ignored otherwise.
REQ-004 stim  output  8  drives Skolem function inputs, stim[k] -> i(k), k=0..7; operand s = stim[3:0], operand t = stim[7:4].
REQ-005 x_in  input  4  Skolem function outputs, x_in[k] <- i(8+k); combinational from stim.
REQ-006 busy  output  1  high from the cycle after an accepted start until done asserts.
REQ-007 done  output  1  one-cycle pulse at sweep end.
REQ-008 pass  output  1  valid from done until the next start; 1 iff fail_count==0.
REQ-009 fail_count  output  9  number of failing (s,t) vectors, 0..256, saturating never needed.
REQ-010 first_fail  output  12  {x_in, stim} of the first failing vector; 0 when no failure.

Function
REQ-011 Target property: for each (s,t), if some x in 0..15 satisfies sge(udiv(x,s), t), then sge(udiv(x_in,s), t) SHALL hold; otherwise the vector passes vacuously.
REQ-012 udiv: 4-bit unsigned; divisor 0 yields 4'hF (SMT-LIB semantics).
REQ-013 sge: 4-bit two's-complement signed greater-or-equal.
REQ-014 FSM states: IDLE, APPLY, SCAN, JUDGE, DONE.
REQ-015 IDLE: stim=0, busy=0; start -> APPLY with stim=8'h00, fail_count and first_fail cleared.
REQ-016 APPLY (1 cycle): stim is stable; x_in is registered into x_cap at the end of the cycle -> SCAN with candidate counter c=0, exists=0.
REQ-017 SCAN (16 cycles, c=0..15): exists |= sge(udiv(c,s),t); after c==15 -> JUDGE; c wraps to 0.
REQ-018 JUDGE (1 cycle): fail = exists & ~sge(udiv(x_cap,s),t); on fail, fail_count increments, and first_fail loads {x_cap,stim} if fail_count was 0.
REQ-019 JUDGE exit: stim==8'hFF -> DONE; otherwise stim increments -> APPLY.
REQ-020 Per-vector latency 18 cycles; full sweep 256*18 = 4608 cycles from start acceptance to DONE entry.
REQ-021 DONE (1 cycle): done=1, busy=0 -> IDLE; pass, fail_count, first_fail hold until the next accepted start.
REQ-022 start while busy SHALL be ignored; no restart, no counter disturbance.
REQ-023 stim SHALL change only on APPLY entry, so x_in is settled for a full cycle before capture.

Reset
REQ-024 rst_n low asynchronously forces IDLE, stim=0, busy=0, done=0, pass=0, fail_count=0, first_fail=0, c=0, exists=0, x_cap=0.
REQ-025 Reset mid-sweep aborts with no done pulse; a fresh start is required.
REQ-026 First start is accepted in the first clock edge after rst_n deasserts.

Configuration
REQ-027 Macro SKCHK_STOP_ON_FAIL_EN: when defined, the first failing JUDGE goes directly to DONE (fail_count=1, pass=0, stim holds the failing vector); when undefined, the sweep always covers all 256 vectors.

Verification
REQ-028 Correct Skolem model on x_in, start -> done after 4608 cycles post-acceptance, pass=1, fail_count=0, first_fail=0.
REQ-029 x_in tied to 4'h0 -> first_fail=12'h011 (s=1, t=1, x=0); vectors 0x00-0x10 pass (0x00, 0x10 vacuously via s=0 -> udiv 4'hF = -1).
REQ-030 x_in tied to 4'h0 with SKCHK_STOP_ON_FAIL_EN defined -> done at vector 0x11 (18*18 = 324 cycles), fail_count=1, pass=0.
REQ-031 rst_n pulsed low at cycle 1000 of a sweep -> all outputs 0 immediately, no done; a subsequent start completes normally.
REQ-032 start re-pulsed at cycles 5 and 2000 of a sweep -> ignored; done still arrives at cycle 4608, counts unchanged from REQ-028/029.

Source files
------------

// File: rtl/skolem_sweep_checker.sv
// ============================================================================
// Module   : skolem_sweep_checker
// Purpose  : Sweeps all 256 (s,t) operand pairs, scans every candidate x, and
//            checks that the external Skolem function output satisfies the
//            udiv/sge property whenever any witness exists.
// Options  : SKCHK_STOP_ON_FAIL_EN - end the sweep at the first failing vector
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module skolem_sweep_checker (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [7:0]  stim,
    input  logic [3:0]  x_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [8:0]  fail_count,
    output logic [11:0] first_fail
);

`ifdef SKCHK_STOP_ON_FAIL_EN
    localparam logic C_STOP_ON_FAIL = 1'b1;
`else
    localparam logic C_STOP_ON_FAIL = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_APPLY = 3'd1,
        S_SCAN  = 3'd2,
        S_JUDGE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      r_state;
    logic [7:0]  r_stim;
    logic [3:0]  r_c;
    logic [3:0]  r_x_cap;
    logic        r_exists;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;
    logic [8:0]  r_fail_count;
    logic [11:0] r_first_fail;

    logic [3:0]  w_s;
    logic [3:0]  w_t;
    logic [3:0]  w_dividend;
    logic [3:0]  w_quot;
    logic        w_ge;
    logic        w_fail;
    logic [8:0]  w_fail_count_nxt;
    logic        w_finish;

    assign w_s = r_stim[3:0];
    assign w_t = r_stim[7:4];

    // One shared divider: candidates are scanned in SCAN, the captured DUT
    // answer is evaluated in JUDGE.
    assign w_dividend       = (r_state == S_JUDGE) ? r_x_cap : r_c;
    assign w_quot           = (w_s == 4'd0) ? 4'hF : (w_dividend / w_s);
    assign w_ge             = ($signed(w_quot) >= $signed(w_t));
    assign w_fail           = r_exists & ~w_ge;
    assign w_fail_count_nxt = r_fail_count + {8'd0, w_fail};
    assign w_finish         = (r_stim == 8'hFF) | (C_STOP_ON_FAIL & w_fail);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_stim       <= 8'h00;
            r_c          <= 4'd0;
            r_x_cap      <= 4'd0;
            r_exists     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_fail_count <= 9'd0;
            r_first_fail <= 12'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state      <= S_APPLY;
                        r_busy       <= 1'b1;
                        r_stim       <= 8'h00;
                        r_pass       <= 1'b0;
                        r_fail_count <= 9'd0;
                        r_first_fail <= 12'd0;
                    end
                end
                S_APPLY: begin
                    r_x_cap  <= x_in;
                    r_c      <= 4'd0;
                    r_exists <= 1'b0;
                    r_state  <= S_SCAN;
                end
                S_SCAN: begin
                    r_exists <= r_exists | w_ge;
                    r_c      <= r_c + 4'd1;
                    if (r_c == 4'hF) begin
                        r_state <= S_JUDGE;
                    end
                end
                S_JUDGE: begin
                    r_fail_count <= w_fail_count_nxt;
                    if (w_fail && (r_fail_count == 9'd0)) begin
                        r_first_fail <= {r_x_cap, r_stim};
                    end
                    if (w_finish) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_pass  <= (w_fail_count_nxt == 9'd0);
                    end else begin
                        // stim only moves on APPLY entry so x_in settles before capture
                        r_stim  <= r_stim + 8'd1;
                        r_state <= S_APPLY;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign stim       = (r_state == S_IDLE) ? 8'h00 : r_stim;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign fail_count = r_fail_count;
    assign first_fail = r_first_fail;

endmodule

`default_nettype wire
